// File: rtl/clkgen_multi.sv
// -----------------------------------------------------------------------------
// clkgen_multi
//
// Multi-channel programmable clock/tick generator. Each channel divides clk by
// a runtime-loadable integer divisor D. It produces a near-50%-duty square wave
// (clk_out) and a one-cycle strobe (tick) on the last cycle of every period.
//
// Divisor writes are double-buffered. A written value waits in a pending
// register, and pend is high while it waits. The value is loaded at the
// channel's period boundary, so the running period is never cut short.
//
// Parameters
//   CHANNELS    number of independent channels (1..16)
//   DIV_W       divisor / counter width
//   DEFAULT_DIV divisor loaded into every channel by reset
//   CH_W        channel-select width, derived (not user-set)
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   en       in   global count enable (0 freezes all counters)
//   wr_en    in   divisor write strobe
//   wr_chan  in   target channel of the write (>= CHANNELS is ignored)
//   wr_div   in   new divisor
//   clk_out  out  per-channel divided square wave, registered
//   tick     out  per-channel one-cycle strobe, registered
//   pend     out  per-channel "divisor waiting for boundary" flag
//   sync     in   only when CLKGEN_SYNC_EN is defined: realign all channels
//
// Optional feature macro: CLKGEN_SYNC_EN (adds the sync port and realign path).
// -----------------------------------------------------------------------------
module clkgen_multi #(
    parameter int CHANNELS    = 4,
    parameter int DIV_W       = 32,
    parameter int DEFAULT_DIV = 524288,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_chan,
    input  logic [DIV_W-1:0]    wr_div,
`ifdef CLKGEN_SYNC_EN
    input  logic                sync,
`endif
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pend
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [DIV_W-1:0] d_q;       // active divisor
        logic [DIV_W-1:0] cnt_q;     // position within the current period
        logic [DIV_W-1:0] p_q;       // pending divisor
        logic             pend_q;
        logic             clk_q;
        logic             tick_q;

        logic [DIV_W-1:0] half;      // ceil(D/2), the number of high cycles
        logic [DIV_W-1:0] last;      // D-1, the boundary count
        logic             active;    // D != 0
        logic             hi;
        logic             at_end;    // boundary cycle while counting
        logic             wr_hit;
        logic             eff_pend;  // pending, including a write in this cycle
        logic [DIV_W-1:0] eff_p;

        always_comb begin
            // (D>>1)+D[0] cannot overflow: for D = all ones it is 2^(DIV_W-1).
            half     = (d_q >> 1) + {{(DIV_W-1){1'b0}}, d_q[0]};
            last     = d_q - DIV_W'(1);
            active   = (d_q != '0);
            hi       = active && (cnt_q < half);
            at_end   = en && active && (cnt_q == last);
            // An out-of-range wr_chan matches no channel index, so the write is dropped.
            wr_hit   = wr_en && (wr_chan == CH_W'(i));
            // A write in the same cycle as an apply point takes effect directly.
            eff_pend = wr_hit | pend_q;
            eff_p    = wr_hit ? wr_div : p_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                d_q    <= DIV_W'(DEFAULT_DIV);
                cnt_q  <= '0;
                p_q    <= '0;
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                // clk_out holds while frozen; tick can only fire while counting.
                if (en) clk_q <= hi;
                tick_q <= at_end;
`ifdef CLKGEN_SYNC_EN
                if (sync) begin
                    // Realign wins over a boundary and ignores en.
                    cnt_q  <= '0;
                    if (eff_pend) d_q <= eff_p;
                    pend_q <= 1'b0;
                end else
`endif
                if (!active) begin
                    // Disabled channel: cnt is already 0. A pending value loads
                    // on the next edge even with en low.
                    if (eff_pend) begin
                        d_q    <= eff_p;
                        pend_q <= 1'b0;
                    end
                end else if (at_end) begin
                    cnt_q  <= '0;
                    if (eff_pend) d_q <= eff_p;
                    pend_q <= 1'b0;
                end else begin
                    if (en) cnt_q <= cnt_q + DIV_W'(1);
                    if (wr_hit) begin
                        p_q    <= wr_div;
                        pend_q <= 1'b1;
                    end
                end
            end
        end

        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
        assign pend[i]    = pend_q;
    end

endmodule

// File: tb/tb_clkgen_multi.sv
// Directed bench for clkgen_multi with CHANNELS=5, DIV_W=8, DEFAULT_DIV=8.
// Inputs change 1 time unit after a rising edge, and outputs are sampled at the
// same point. "After edge k" therefore refers to the registered outputs that edge k produced.
module tb_clkgen_multi;
    localparam int CHANNELS = 5;
    localparam int DIV_W    = 8;
    localparam int CH_W     = 3;

    logic                clk;
    logic                rst;
    logic                en;
    logic                wr_en;
    logic [CH_W-1:0]     wr_chan;
    logic [DIV_W-1:0]    wr_div;
`ifdef CLKGEN_SYNC_EN
    logic                sync;
`endif
    logic [CHANNELS-1:0] clk_out;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] pend;

    int n_cmp = 0;
    int n_err = 0;

    clkgen_multi #(
        .CHANNELS   (CHANNELS),
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .wr_en  (wr_en),
        .wr_chan(wr_chan),
        .wr_div (wr_div),
`ifdef CLKGEN_SYNC_EN
        .sync   (sync),
`endif
        .clk_out(clk_out),
        .tick   (tick),
        .pend   (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int ch, input int d);
        wr_en   = 1'b1;
        wr_chan = CH_W'(ch);
        wr_div  = DIV_W'(d);
    endtask

    // Steps until tick[ch] is high. Afterwards that channel's cnt is 0.
    task automatic wait_tick(input int ch);
        int n;
        n = 0;
        step();
        while (tick[ch] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        n_cmp++;
        if (tick[ch] !== 1'b1) begin
            n_err++;
            $display("FAIL wait_tick ch%0d: tick=%b after 40 cycles, required 1", ch, tick[ch]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_chan = '0; wr_div = '0;
`ifdef CLKGEN_SYNC_EN
        sync = 1'b0;
`endif
        repeat (3) step();
        n_cmp++; if (clk_out !== 5'b0) begin n_err++; $display("FAIL reset_clk_out: got %b required 00000", clk_out); end
        n_cmp++; if (tick !== 5'b0)    begin n_err++; $display("FAIL reset_tick: got %b required 00000", tick); end
        n_cmp++; if (pend !== 5'b0)    begin n_err++; $display("FAIL reset_pend: got %b required 00000", pend); end
        rst = 1'b0;
        en  = 1'b1;
        // D=8 from reset: after edges 1..16 the outputs follow 1111 0000, with tick on the last 0.
        begin
            logic [15:0] pc, pt;
            pc = 16'b1111_0000_1111_0000;
            pt = 16'b0000_0001_0000_0001;
            for (int k = 0; k < 16; k++) begin
                step();
                n_cmp++;
                if (clk_out[0] !== pc[15-k] || tick[0] !== pt[15-k]) begin
                    n_err++;
                    $display("FAIL default_div edge%0d: clk_out0=%b tick0=%b required %b %b",
                             k+1, clk_out[0], tick[0], pc[15-k], pt[15-k]);
                end
            end
        end
    endtask

    // Write D=5 to ch1 mid-period. The old 8-cycle period must finish first.
    task automatic test_write_mid_period();
        logic [9:0] pc, pt;
        step(); step();                // ch1 cnt = 2
        write(1, 5);
        step();                        // cnt = 3, pend rises
        wr_en = 1'b0;
        n_cmp++; if (pend[1] !== 1'b1) begin n_err++; $display("FAIL wr_pend_rise: pend1=%b required 1", pend[1]); end
        for (int k = 0; k < 4; k++) begin
            step();                    // cnt 4..7
            n_cmp++;
            if (pend[1] !== 1'b1 || tick[1] !== 1'b0) begin
                n_err++;
                $display("FAIL wr_pend_hold %0d: pend1=%b tick1=%b required 1 0", k, pend[1], tick[1]);
            end
        end
        step();                        // old boundary: load D=5
        n_cmp++;
        if (pend[1] !== 1'b0 || tick[1] !== 1'b1 || clk_out[1] !== 1'b0) begin
            n_err++;
            $display("FAIL wr_apply: pend1=%b tick1=%b clk1=%b required 0 1 0", pend[1], tick[1], clk_out[1]);
        end
        pc = 10'b11100_11100;
        pt = 10'b00001_00001;
        for (int k = 0; k < 10; k++) begin
            step();
            n_cmp++;
            if (clk_out[1] !== pc[9-k] || tick[1] !== pt[9-k]) begin
                n_err++;
                $display("FAIL div5 cycle%0d: clk1=%b tick1=%b required %b %b", k, clk_out[1], tick[1], pc[9-k], pt[9-k]);
            end
        end
    endtask

    // Disable ch2 with D=0, then restart it with D=3 immediately.
    task automatic test_disable();
        logic [5:0] pc, pt;
        wait_tick(2);                  // ch2 cnt = 0
        step(); step();                // cnt = 2
        write(2, 0);
        step();
        wr_en = 1'b0;
        n_cmp++; if (pend[2] !== 1'b1) begin n_err++; $display("FAIL dis_pend: pend2=%b required 1", pend[2]); end
        repeat (4) step();
        step();                        // boundary loads D=0
        n_cmp++;
        if (pend[2] !== 1'b0 || tick[2] !== 1'b1) begin
            n_err++;
            $display("FAIL dis_apply: pend2=%b tick2=%b required 0 1", pend[2], tick[2]);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++;
            if (clk_out[2] !== 1'b0 || tick[2] !== 1'b0 || pend[2] !== 1'b0) begin
                n_err++;
                $display("FAIL dis_idle %0d: clk2=%b tick2=%b pend2=%b required 0 0 0", k, clk_out[2], tick[2], pend[2]);
            end
        end
        write(2, 3);
        step();                        // D=3 loaded on this edge
        wr_en = 1'b0;
        n_cmp++;
        if (pend[2] !== 1'b0 || clk_out[2] !== 1'b0) begin
            n_err++;
            $display("FAIL dis_reload: pend2=%b clk2=%b required 0 0", pend[2], clk_out[2]);
        end
        pc = 6'b110_110;
        pt = 6'b001_001;
        for (int k = 0; k < 6; k++) begin
            step();
            n_cmp++;
            if (clk_out[2] !== pc[5-k] || tick[2] !== pt[5-k]) begin
                n_err++;
                $display("FAIL div3 cycle%0d: clk2=%b tick2=%b required %b %b", k, clk_out[2], tick[2], pc[5-k], pt[5-k]);
            end
        end
    endtask

    // Freeze for 10 cycles with ch0 at cnt=2. A write during the freeze must stay pending.
    task automatic test_freeze();
        logic [5:0] pc, pt;
        wait_tick(0);                  // ch0 cnt = 0
        step(); step();                // cnt = 2, clk_out0 = 1
        en = 1'b0;
        write(1, 6);
        for (int k = 0; k < 10; k++) begin
            step();
            wr_en = 1'b0;
            n_cmp++;
            if (clk_out[0] !== 1'b1 || tick !== 5'b0 || pend[1] !== 1'b1) begin
                n_err++;
                $display("FAIL freeze %0d: clk0=%b tick=%b pend1=%b required 1 00000 1", k, clk_out[0], tick, pend[1]);
            end
        end
        en = 1'b1;
        pc = 6'b110000;
        pt = 6'b000001;
        for (int k = 0; k < 6; k++) begin
            step();
            n_cmp++;
            if (clk_out[0] !== pc[5-k] || tick[0] !== pt[5-k]) begin
                n_err++;
                $display("FAIL resume cycle%0d: clk0=%b tick0=%b required %b %b", k, clk_out[0], tick[0], pc[5-k], pt[5-k]);
            end
        end
    endtask

    // Write D=4 to ch0 in its boundary cycle. It applies at once and pend never rises.
    task automatic test_boundary_write();
        logic [7:0] pc, pt;
        wait_tick(0);
        repeat (7) step();             // ch0 cnt = 7
        write(0, 4);
        step();
        wr_en = 1'b0;
        n_cmp++;
        if (pend[0] !== 1'b0 || tick[0] !== 1'b1) begin
            n_err++;
            $display("FAIL bnd_write: pend0=%b tick0=%b required 0 1", pend[0], tick[0]);
        end
        pc = 8'b1100_1100;
        pt = 8'b0001_0001;
        for (int k = 0; k < 8; k++) begin
            step();
            n_cmp++;
            if (clk_out[0] !== pc[7-k] || tick[0] !== pt[7-k] || pend[0] !== 1'b0) begin
                n_err++;
                $display("FAIL div4 cycle%0d: clk0=%b tick0=%b pend0=%b required %b %b 0",
                         k, clk_out[0], tick[0], pend[0], pc[7-k], pt[7-k]);
            end
        end
    endtask

    // Two writes to ch4 before its boundary. The second value (3) must be the one that loads.
    task automatic test_last_write_wins();
        logic [5:0] pc, pt;
        wait_tick(4);
        step();                        // cnt = 1
        write(4, 2);
        step();                        // cnt = 2
        n_cmp++; if (pend[4] !== 1'b1) begin n_err++; $display("FAIL lww_first: pend4=%b required 1", pend[4]); end
        write(4, 3);
        step();                        // cnt = 3
        wr_en = 1'b0;
        repeat (4) step();             // cnt = 7
        n_cmp++; if (pend[4] !== 1'b1) begin n_err++; $display("FAIL lww_hold: pend4=%b required 1", pend[4]); end
        step();
        n_cmp++;
        if (pend[4] !== 1'b0 || tick[4] !== 1'b1) begin
            n_err++;
            $display("FAIL lww_apply: pend4=%b tick4=%b required 0 1", pend[4], tick[4]);
        end
        pc = 6'b110_110;
        pt = 6'b001_001;
        for (int k = 0; k < 6; k++) begin
            step();
            n_cmp++;
            if (clk_out[4] !== pc[5-k] || tick[4] !== pt[5-k]) begin
                n_err++;
                $display("FAIL lww_div3 cycle%0d: clk4=%b tick4=%b required %b %b", k, clk_out[4], tick[4], pc[5-k], pt[5-k]);
            end
        end
    endtask

    // D=1 on ch3, then writes to channel numbers 5 and 7, which do not exist.
    task automatic test_div1_and_oob();
        int n;
        write(3, 1);
        step();
        wr_en = 1'b0;
        n = 0;
        while (pend[3] !== 1'b0 && n < 10) begin
            step();
            n++;
        end
        n_cmp++; if (pend[3] !== 1'b0) begin n_err++; $display("FAIL d1_apply: pend3=%b required 0", pend[3]); end
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++;
            if (clk_out[3] !== 1'b1 || tick[3] !== 1'b1) begin
                n_err++;
                $display("FAIL div1 %0d: clk3=%b tick3=%b required 1 1", k, clk_out[3], tick[3]);
            end
        end
        write(5, 2);
        step();
        n_cmp++; if (pend !== 5'b0) begin n_err++; $display("FAIL oob5: pend=%b required 00000", pend); end
        write(7, 2);
        step();
        wr_en = 1'b0;
        n_cmp++; if (pend !== 5'b0) begin n_err++; $display("FAIL oob7: pend=%b required 00000", pend); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (clk_out[3] !== 1'b1 || tick[3] !== 1'b1 || pend !== 5'b0) begin
                n_err++;
                $display("FAIL oob_after %0d: clk3=%b tick3=%b pend=%b required 1 1 00000", k, clk_out[3], tick[3], pend);
            end
        end
    endtask

`ifdef CLKGEN_SYNC_EN
    // Pulse sync together with a write. All channels restart at cnt=0 and rise together.
    task automatic test_sync();
        sync = 1'b1;
        write(1, 7);
        step();
        sync  = 1'b0;
        wr_en = 1'b0;
        n_cmp++; if (pend !== 5'b0) begin n_err++; $display("FAIL sync_pend: pend=%b required 00000", pend); end
        step();
        n_cmp++; if (clk_out !== 5'b11111) begin n_err++; $display("FAIL sync_rise: clk_out=%b required 11111", clk_out); end
        step();
        n_cmp++; if (clk_out !== 5'b11111) begin n_err++; $display("FAIL sync_hold: clk_out=%b required 11111", clk_out); end
    endtask
`endif

    // Assert reset mid-period with a write pending. Afterwards the divisor is back to 8.
    task automatic test_reset_mid();
        logic [7:0] pc, pt;
        wait_tick(0);
        step();                        // cnt = 1
        write(0, 7);
        step();
        wr_en = 1'b0;
        n_cmp++; if (pend[0] !== 1'b1) begin n_err++; $display("FAIL rstmid_pend_before: pend0=%b required 1", pend[0]); end
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (clk_out !== 5'b0 || tick !== 5'b0 || pend !== 5'b0) begin
            n_err++;
            $display("FAIL rstmid_async: clk_out=%b tick=%b pend=%b required all 0", clk_out, tick, pend);
        end
        step();
        rst = 1'b0;
        pc = 8'b1111_0000;
        pt = 8'b0000_0001;
        for (int k = 0; k < 8; k++) begin
            step();
            n_cmp++;
            if (clk_out[0] !== pc[7-k] || tick[0] !== pt[7-k]) begin
                n_err++;
                $display("FAIL rstmid_div8 cycle%0d: clk0=%b tick0=%b required %b %b", k, clk_out[0], tick[0], pc[7-k], pt[7-k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_mid_period();
        test_disable();
        test_freeze();
        test_boundary_write();
        test_last_write_wins();
        test_div1_and_oob();
`ifdef CLKGEN_SYNC_EN
        test_sync();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
